// File: rtl/subword_scheduler_if.sv
// Purpose: bundles the key, state and S-box lane signals of subword_scheduler.
// Latency: none. This file only groups wires.
// Backpressure: req/gnt handshakes with requesters; the S-box lanes have fixed latency and no stall.
// Ports: key request/grant/result, state request/grant/result, shared S-box issue and return words.
interface subword_scheduler_if;
    logic         i_kx_req;
    logic [31:0]  i_kx_word;
    logic         o_kx_gnt;
    logic         o_kx_valid;
    logic [31:0]  o_kx_dout;

    logic         i_st_req;
    logic         i_st_inv;
    logic [127:0] i_st_din;
    logic         o_st_gnt;
    logic         o_st_valid;
    logic [127:0] o_st_dout;

    logic [31:0]  o_sw_din;
    logic         o_sw_issue;
    logic [31:0]  i_sw_fwd_dout;
    logic [31:0]  i_sw_inv_dout;

    // Scheduler side
    modport slave (
        input  i_kx_req, i_kx_word, i_st_req, i_st_inv, i_st_din,
               i_sw_fwd_dout, i_sw_inv_dout,
        output o_kx_gnt, o_kx_valid, o_kx_dout, o_st_gnt, o_st_valid, o_st_dout,
               o_sw_din, o_sw_issue
    );

    // Requester / S-box side
    modport master (
        output i_kx_req, i_kx_word, i_st_req, i_st_inv, i_st_din,
               i_sw_fwd_dout, i_sw_inv_dout,
        input  o_kx_gnt, o_kx_valid, o_kx_dout, o_st_gnt, o_st_valid, o_st_dout,
               o_sw_din, o_sw_issue
    );
endinterface

// File: rtl/subword_scheduler.sv
// Purpose: shares one 32-bit SubWords unit between key expansion (1 word) and the round state (4 words).
// Latency: key grant T -> o_kx_valid T+2+SBOX_LAT; state grant T -> o_st_valid T+5+SBOX_LAT.
// Backpressure: requests are held until a one-cycle grant, which is issued only in IDLE. Results never stall.
// Ports: i_clk, i_rst (async, active high), bus (subword_scheduler_if.slave).
module subword_scheduler #(
    parameter int SBOX_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    subword_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY  = 3'd1,
        S0   = 3'd2,
        S1   = 3'd3,
        S2   = 3'd4,
        S3   = 3'd5
    } state_t;

    // Travels alongside each issued word so its result can be routed back.
    typedef struct packed {
        logic       vld;
        logic       own_st;  // 1 = state job, 0 = key job
        logic       inv;
        logic [1:0] idx;     // word index within the state, 0 = bits [127:96]
    } tag_t;

    state_t             state_q, state_d;
    logic               last_st_q, last_st_d;   // 1 = state was served last
    logic [95:0]        in_q, in_d;             // words 1..3 of the latched state
    logic               inv_q, inv_d;
    logic [31:0]        sw_din_q, sw_din_d;
    logic               sw_issue_q, sw_issue_d;
    tag_t               iss_tag_q, iss_tag_d;
    tag_t               tag_q [SBOX_LAT];
    tag_t               tag_d [SBOX_LAT];
    logic [3:0][31:0]   asm_q, asm_d;
    logic [31:0]        kx_dout_q, kx_dout_d;
    logic               kx_valid_q, kx_valid_d;
    logic [127:0]       st_dout_q, st_dout_d;
    logic               st_valid_q, st_valid_d;

    logic               kx_gnt, st_gnt;
    tag_t               ex;
    logic [31:0]        res;

    // Tie-break: key wins unless the key was served last. Grants are held low during reset.
    assign kx_gnt = (state_q == IDLE) && !i_rst && bus.i_kx_req &&
                    (!bus.i_st_req || last_st_q);
    assign st_gnt = (state_q == IDLE) && !i_rst && bus.i_st_req &&
                    (!bus.i_kx_req || !last_st_q);

    assign ex  = tag_q[SBOX_LAT-1];
    assign res = ex.inv ? bus.i_sw_inv_dout : bus.i_sw_fwd_dout;

    // Issue side. Word 0 of each job is driven directly from the grant cycle
    // inputs, so the issue register is loaded one cycle ahead of the FSM state
    // that names it.
    always_comb begin
        state_d    = state_q;
        last_st_d  = last_st_q;
        in_d       = in_q;
        inv_d      = inv_q;
        sw_din_d   = 32'd0;
        sw_issue_d = 1'b0;
        iss_tag_d  = '0;
        case (state_q)
            IDLE: begin
                if (kx_gnt) begin
                    state_d    = KEY;
                    last_st_d  = 1'b0;
                    sw_din_d   = bus.i_kx_word;
                    sw_issue_d = 1'b1;
                    iss_tag_d  = '{vld: 1'b1, own_st: 1'b0, inv: 1'b0, idx: 2'd0};
                end else if (st_gnt) begin
                    state_d    = S0;
                    last_st_d  = 1'b1;
                    in_d       = bus.i_st_din[95:0];
                    inv_d      = bus.i_st_inv;
                    sw_din_d   = bus.i_st_din[127:96];
                    sw_issue_d = 1'b1;
                    iss_tag_d  = '{vld: 1'b1, own_st: 1'b1, inv: bus.i_st_inv, idx: 2'd0};
                end
            end
            KEY: state_d = IDLE;
            S0: begin
                state_d    = S1;
                sw_din_d   = in_q[95:64];
                sw_issue_d = 1'b1;
                iss_tag_d  = '{vld: 1'b1, own_st: 1'b1, inv: inv_q, idx: 2'd1};
            end
            S1: begin
                state_d    = S2;
                sw_din_d   = in_q[63:32];
                sw_issue_d = 1'b1;
                iss_tag_d  = '{vld: 1'b1, own_st: 1'b1, inv: inv_q, idx: 2'd2};
            end
            S2: begin
                state_d    = S3;
                sw_din_d   = in_q[31:0];
                sw_issue_d = 1'b1;
                iss_tag_d  = '{vld: 1'b1, own_st: 1'b1, inv: inv_q, idx: 2'd3};
            end
            S3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The tag shift register lines each tag up with its S-box result.
    always_comb begin
        tag_d[0] = iss_tag_q;
        for (int i = 1; i < SBOX_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Return side. The delivered state is a separate register from the
    // assembly, so a following job cannot disturb a delivered result.
    always_comb begin
        asm_d      = asm_q;
        kx_dout_d  = kx_dout_q;
        kx_valid_d = 1'b0;
        st_dout_d  = st_dout_q;
        st_valid_d = 1'b0;
        if (ex.vld) begin
            if (!ex.own_st) begin
                kx_dout_d  = res;
                kx_valid_d = 1'b1;
            end else begin
                asm_d[ex.idx] = res;
                if (ex.idx == 2'd3) begin
                    st_dout_d  = {asm_q[0], asm_q[1], asm_q[2], res};
                    st_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_st_q  <= 1'b1;
            in_q       <= '0;
            inv_q      <= 1'b0;
            sw_din_q   <= '0;
            sw_issue_q <= 1'b0;
            iss_tag_q  <= '0;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_q[i] <= '0;
            end
            asm_q      <= '0;
            kx_dout_q  <= '0;
            kx_valid_q <= 1'b0;
            st_dout_q  <= '0;
            st_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_st_q  <= last_st_d;
            in_q       <= in_d;
            inv_q      <= inv_d;
            sw_din_q   <= sw_din_d;
            sw_issue_q <= sw_issue_d;
            iss_tag_q  <= iss_tag_d;
            for (int i = 0; i < SBOX_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            asm_q      <= asm_d;
            kx_dout_q  <= kx_dout_d;
            kx_valid_q <= kx_valid_d;
            st_dout_q  <= st_dout_d;
            st_valid_q <= st_valid_d;
        end
    end

    assign bus.o_kx_gnt   = kx_gnt;
    assign bus.o_st_gnt   = st_gnt;
    assign bus.o_kx_valid = kx_valid_q;
    assign bus.o_kx_dout  = kx_dout_q;
    assign bus.o_st_valid = st_valid_q;
    assign bus.o_st_dout  = st_dout_q;
    assign bus.o_sw_din   = sw_din_q;
    assign bus.o_sw_issue = sw_issue_q;

endmodule

// File: tb/tb_subword_scheduler.sv
// Purpose: directed checks of subword_scheduler with AES S-box lanes modelled at latency 1 and 3.
// Latency: the lane models register the substituted word SBOX_LAT times.
// Backpressure: the bench holds requests until grant, as a requester would.
module tb_subword_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    subword_scheduler_if bus1();
    subword_scheduler_if bus2();

    subword_scheduler #(.SBOX_LAT(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    subword_scheduler #(.SBOX_LAT(3)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

    int n_run;
    int n_fail;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'd0;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8] = inv ? isb[w[8*k +: 8]] : sb[w[8*k +: 8]];
        end
        return r;
    endfunction

    // Registered S-box lane models.
    logic [31:0] f1_q, i1_q;
    logic [31:0] f2_q [3];
    logic [31:0] i2_q [3];
    always @(posedge clk) begin
        f1_q    <= subw(bus1.o_sw_din, 1'b0);
        i1_q    <= subw(bus1.o_sw_din, 1'b1);
        f2_q[0] <= subw(bus2.o_sw_din, 1'b0);
        i2_q[0] <= subw(bus2.o_sw_din, 1'b1);
        f2_q[1] <= f2_q[0];
        i2_q[1] <= i2_q[0];
        f2_q[2] <= f2_q[1];
        i2_q[2] <= i2_q[1];
    end
    assign bus1.i_sw_fwd_dout = f1_q;
    assign bus1.i_sw_inv_dout = i1_q;
    assign bus2.i_sw_fwd_dout = f2_q[2];
    assign bus2.i_sw_inv_dout = i2_q[2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
        #1;
    endtask

    logic [127:0] fin, fout;
    logic [31:0]  kw, kexp;
    logic [17:0]  m_kg, m_sg, m_kv, m_sv, m_is;
    logic         seen;

    initial begin
        n_run  = 0;
        n_fail = 0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b;
            logic [7:0] s;
            b = 8'd0;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'd1) b = 8'(y);
                end
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end

        fin  = 128'h19A09AE9_3DF4C6F8_E3E28D48_BE2B2A08;
        fout = 128'hD4E0B81E_27BFB441_11985D52_AEF1E530;
        kw   = 32'hA0FAFE17;
        kexp = subw(kw, 1'b0);

        rst = 1'b1;
        bus1.i_kx_req = 1'b1; bus1.i_kx_word = kw;
        bus1.i_st_req = 1'b1; bus1.i_st_din  = fin; bus1.i_st_inv = 1'b0;
        bus2.i_kx_req = 1'b0; bus2.i_kx_word = 32'd0;
        bus2.i_st_req = 1'b0; bus2.i_st_din  = '0;  bus2.i_st_inv = 1'b0;

        // Reset state, with both requests already pending.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sw_din", bus1.o_sw_din, 0);
        chk("rst_issue", bus1.o_sw_issue, 0);
        chk("rst_kx_gnt", bus1.o_kx_gnt, 0);
        chk("rst_st_gnt", bus1.o_st_gnt, 0);
        chk("rst_kx_valid", bus1.o_kx_valid, 0);
        chk("rst_st_valid", bus1.o_st_valid, 0);
        chk("rst_kx_dout", bus1.o_kx_dout, 0);
        chk("rst_st_dout", bus1.o_st_dout, 0);

        // Tie / fairness: both requests held from reset release.
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 10) begin
                bus1.i_kx_req = 1'b0;
                bus1.i_st_req = 1'b0;
            end
            #1;
            m_kg[c] = bus1.o_kx_gnt;
            m_sg[c] = bus1.o_st_gnt;
            m_kv[c] = bus1.o_kx_valid;
            m_sv[c] = bus1.o_st_valid;
            m_is[c] = bus1.o_sw_issue;
            if (c == 3 || c == 10) chk("tie_kx_dout", bus1.o_kx_dout, kexp);
            if (c == 8 || c == 15) chk("tie_st_dout", bus1.o_st_dout, fout);
        end
        chk("tie_kx_gnt_pattern", m_kg, 18'h00081);
        chk("tie_st_gnt_pattern", m_sg, 18'h00204);
        chk("tie_kx_valid_pattern", m_kv, 18'h00408);
        chk("tie_st_valid_pattern", m_sv, 18'h08100);
        chk("tie_issue_pattern", m_is, 18'h03D7A);

        // Key job.
        @(negedge clk);
        bus1.i_kx_req = 1'b1; bus1.i_kx_word = 32'h00010253;
        #1;
        chk("key_gnt", bus1.o_kx_gnt, 1);
        chk("key_no_st_gnt", bus1.o_st_gnt, 0);
        @(posedge clk); #1;
        bus1.i_kx_req = 1'b0; bus1.i_kx_word = 32'hDEADBEEF;
        nc();
        chk("key_issue_t1", bus1.o_sw_issue, 1);
        chk("key_sw_din_t1", bus1.o_sw_din, 32'h00010253);
        nc();
        chk("key_issue_t2", bus1.o_sw_issue, 0);
        chk("key_sw_din_t2", bus1.o_sw_din, 0);
        chk("key_valid_t2", bus1.o_kx_valid, 0);
        nc();
        chk("key_valid_t3", bus1.o_kx_valid, 1);
        chk("key_dout_t3", bus1.o_kx_dout, 32'h637C77ED);
        nc();
        chk("key_valid_t4", bus1.o_kx_valid, 0);
        chk("key_dout_hold", bus1.o_kx_dout, 32'h637C77ED);

        // Forward state job.
        @(negedge clk);
        bus1.i_st_req = 1'b1; bus1.i_st_din = fin; bus1.i_st_inv = 1'b0;
        #1;
        chk("fwd_gnt", bus1.o_st_gnt, 1);
        @(posedge clk); #1;
        bus1.i_st_req = 1'b0; bus1.i_st_din = '1;
        for (int k = 0; k < 4; k++) begin
            nc();
            chk("fwd_issue", bus1.o_sw_issue, 1);
            chk("fwd_sw_din", bus1.o_sw_din, fin[127-32*k -: 32]);
            chk("fwd_valid_early", bus1.o_st_valid, 0);
        end
        nc();
        chk("fwd_issue_t5", bus1.o_sw_issue, 0);
        chk("fwd_valid_t5", bus1.o_st_valid, 0);
        nc();
        chk("fwd_valid_t6", bus1.o_st_valid, 1);
        chk("fwd_dout", bus1.o_st_dout, fout);
        nc();
        chk("fwd_valid_t7", bus1.o_st_valid, 0);
        chk("fwd_dout_hold", bus1.o_st_dout, fout);

        // Inverse state job, with a key request raised and dropped mid-job.
        @(negedge clk);
        bus1.i_st_req = 1'b1; bus1.i_st_din = fout; bus1.i_st_inv = 1'b1;
        #1;
        chk("inv_gnt", bus1.o_st_gnt, 1);
        @(posedge clk); #1;
        bus1.i_st_req = 1'b0; bus1.i_st_inv = 1'b0;
        nc();
        chk("inv_sw_din_w0", bus1.o_sw_din, 32'hD4E0B81E);
        @(negedge clk);
        bus1.i_kx_req = 1'b1; bus1.i_kx_word = 32'h12345678;
        #1;
        chk("busy_no_kx_gnt", bus1.o_kx_gnt, 0);
        @(negedge clk);
        bus1.i_kx_req = 1'b0;
        #1;
        seen = 1'b0;
        for (int c = 3; c < 6; c++) begin
            if (c > 3) nc();
            seen = seen | bus1.o_kx_valid | bus1.o_st_valid;
        end
        chk("inv_no_early_valid", seen, 0);
        nc();
        chk("inv_valid_t6", bus1.o_st_valid, 1);
        chk("inv_dout", bus1.o_st_dout, fin);
        chk("cancel_kx_dout_kept", bus1.o_kx_dout, 32'h637C77ED);
        nc();
        chk("inv_valid_t7", bus1.o_st_valid, 0);
        chk("cancel_no_kx_valid", bus1.o_kx_valid, 0);

        // Back-to-back state jobs on the latency-3 instance.
        m_sg = '0;
        m_sv = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus2.i_st_req = 1'b1; bus2.i_st_din = fin; bus2.i_st_inv = 1'b0;
            end
            if (c == 1) begin
                bus2.i_st_din = fout; bus2.i_st_inv = 1'b1;
            end
            if (c == 6) bus2.i_st_req = 1'b0;
            #1;
            m_sg[c] = bus2.o_st_gnt;
            m_sv[c] = bus2.o_st_valid;
            if (c >= 8 && c < 13) chk("b2b_dout_first", bus2.o_st_dout, fout);
            if (c >= 13) chk("b2b_dout_second", bus2.o_st_dout, fin);
        end
        chk("b2b_gnt_pattern", m_sg[15:0], 16'h0021);
        chk("b2b_valid_pattern", m_sv[15:0], 16'h2100);

        // Reset in the middle of a state job (cycle S2).
        @(negedge clk);
        bus1.i_st_req = 1'b1; bus1.i_st_din = fin; bus1.i_st_inv = 1'b0;
        #1;
        chk("rj_gnt", bus1.o_st_gnt, 1);
        @(posedge clk); #1;
        bus1.i_st_req = 1'b0;
        nc();
        nc();
        nc();
        chk("rj_s2_issue", bus1.o_sw_issue, 1);
        chk("rj_s2_sw_din", bus1.o_sw_din, fin[63:32]);
        rst = 1'b1;
        bus1.i_kx_req = 1'b1;
        #1;
        chk("rj_sw_din", bus1.o_sw_din, 0);
        chk("rj_issue", bus1.o_sw_issue, 0);
        chk("rj_kx_dout", bus1.o_kx_dout, 0);
        chk("rj_st_dout", bus1.o_st_dout, 0);
        chk("rj_kx_gnt", bus1.o_kx_gnt, 0);
        chk("rj_st_valid", bus1.o_st_valid, 0);
        chk("rj_dut2_st_dout", bus2.o_st_dout, 0);
        @(negedge clk);
        bus1.i_kx_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) nc();
            seen = seen | bus1.o_st_valid | bus1.o_kx_valid | bus1.o_sw_issue;
        end
        chk("rj_no_valid_after_release", seen, 0);
        chk("rj_st_dout_after", bus1.o_st_dout, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
